// File: rtl/bpu_renew_ctrl.sv
// BPU training controller: takes committed branches, raises a registered
// redirect on mispredict and queues training updates toward the BPU.
module bpu_renew_ctrl #(
  parameter int DEPTH = 8,
  parameter int PHT_W = 10,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cm_valid,
  input  logic [1:0][31:0]      cm_pc,
  input  logic [1:0]            cm_taken,
  input  logic [1:0][31:0]      cm_target,
  input  logic [1:0]            cm_pred_taken,
  input  logic [1:0][31:0]      cm_pred_target,
  input  logic [1:0][PHT_W-1:0] cm_pht_idx,
  output logic                  cm_ready,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [PHT_W-1:0]      upd_pht_idx,
  output logic                  upd_taken,
  output logic                  upd_btb_en,
  output logic [31:0]           upd_pc,
  output logic [31:0]           upd_target,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic [CNT_W-1:0]      cnt_branch,
  output logic [CNT_W-1:0]      cnt_mispred
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO = (AW+1)'(2);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       free;
  logic [AW-1:0]     wr_idx0;
  logic [AW-1:0]     wr_idx1;
  logic [AW-1:0]     rd_idx;

  logic [PHT_W-1:0]  mem_pht [DEPTH];
  logic              mem_tk  [DEPTH];
  logic [31:0]       mem_pc  [DEPTH];
  logic [31:0]       mem_tgt [DEPTH];

  logic [1:0]        mispred;
  logic              acc0;
  logic              keep1;
  logic              pop;
  logic [1:0]        push_n;
  logic              rd_fire;
  logic              rd_sel;
  logic [31:0]       rd_pc_nxt;

  logic [CNT_W:0]    br_sum;
  logic [CNT_W:0]    mp_sum;

  assign count    = wr_ptr - rd_ptr;
  assign free     = DEPTH_P - count;
  assign cm_ready = free >= TWO;

  always_comb begin
    mispred = '0;
    for (int i = 0; i < 2; i++) begin
      mispred[i] = (cm_taken[i] != cm_pred_taken[i]) |
                   (cm_taken[i] & (cm_target[i] != cm_pred_target[i]));
    end
  end

  // Slot 1 is wrong-path whenever the older slot 0 mispredicts.
  assign acc0   = cm_valid[0] & cm_ready;
  assign keep1  = cm_valid[1] & cm_ready & ~(cm_valid[0] & mispred[0]);
  assign push_n = {1'b0, acc0} + {1'b0, keep1};
  assign pop    = upd_valid & upd_ready;

  assign wr_idx0 = wr_ptr[AW-1:0];
  assign wr_idx1 = wr_ptr[AW-1:0] + AW'(acc0);
  assign rd_idx  = rd_ptr[AW-1:0];

  always_comb begin
    rd_fire   = 1'b0;
    rd_sel    = 1'b0;
    rd_pc_nxt = '0;
    if (acc0 & mispred[0]) begin
      rd_fire = 1'b1;
      rd_sel  = 1'b0;
    end else if (keep1 & mispred[1]) begin
      rd_fire = 1'b1;
      rd_sel  = 1'b1;
    end
    if (cm_taken[rd_sel])
      rd_pc_nxt = cm_target[rd_sel];
    else
      rd_pc_nxt = cm_pc[rd_sel] + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (acc0) begin
      mem_pht[wr_idx0] <= cm_pht_idx[0];
      mem_tk[wr_idx0]  <= cm_taken[0];
      mem_pc[wr_idx0]  <= cm_pc[0];
      mem_tgt[wr_idx0] <= cm_target[0];
    end
    if (keep1) begin
      mem_pht[wr_idx1] <= cm_pht_idx[1];
      mem_tk[wr_idx1]  <= cm_taken[1];
      mem_pc[wr_idx1]  <= cm_pc[1];
      mem_tgt[wr_idx1] <= cm_target[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push_n);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= rd_fire;
      if (rd_fire)
        redirect_pc <= rd_pc_nxt;
    end
  end

  // The extra sum bit is the saturation flag.
  assign br_sum = {1'b0, cnt_branch} + (CNT_W+1)'(push_n);
  assign mp_sum = {1'b0, cnt_mispred} + (CNT_W+1)'(rd_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else begin
      cnt_branch  <= br_sum[CNT_W] ? '1 : br_sum[CNT_W-1:0];
      cnt_mispred <= mp_sum[CNT_W] ? '1 : mp_sum[CNT_W-1:0];
    end
  end

  assign upd_valid   = count != '0;
  assign upd_pht_idx = mem_pht[rd_idx];
  assign upd_taken   = mem_tk[rd_idx];
  assign upd_btb_en  = mem_tk[rd_idx];
  assign upd_pc      = mem_pc[rd_idx];
  assign upd_target  = mem_tgt[rd_idx];

endmodule

// File: tb/tb_bpu_renew_ctrl.sv
// Bench for bpu_renew_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_bpu_renew_ctrl;

  localparam int PW = 10;
  localparam int CW = 8;
  localparam int DEPTH = 8;
  localparam longint CMAX = 255;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] cm_valid;
  logic [1:0][31:0] cm_pc;
  logic [1:0] cm_taken;
  logic [1:0][31:0] cm_target;
  logic [1:0] cm_pred_taken;
  logic [1:0][31:0] cm_pred_target;
  logic [1:0][PW-1:0] cm_pht_idx;
  logic cm_ready;
  logic upd_valid;
  logic upd_ready;
  logic [PW-1:0] upd_pht_idx;
  logic upd_taken;
  logic upd_btb_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic [CW-1:0] cnt_branch;
  logic [CW-1:0] cnt_mispred;

  always #5 clk = ~clk;

  bpu_renew_ctrl #(.DEPTH(DEPTH), .PHT_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_taken(cm_taken),
    .cm_target(cm_target), .cm_pred_taken(cm_pred_taken),
    .cm_pred_target(cm_pred_target), .cm_pht_idx(cm_pht_idx),
    .cm_ready(cm_ready), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pht_idx(upd_pht_idx), .upd_taken(upd_taken),
    .upd_btb_en(upd_btb_en), .upd_pc(upd_pc), .upd_target(upd_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  typedef struct {
    logic [PW-1:0] pht;
    logic          tk;
    logic [31:0]   pc;
    logic [31:0]   tgt;
  } ent_t;

  ent_t q[$];
  logic exp_rv;
  logic [31:0] exp_rpc;
  longint exp_cb, exp_cm;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic clr_in();
    cm_valid = '0; cm_pc = '0; cm_taken = '0; cm_target = '0;
    cm_pred_taken = '0; cm_pred_target = '0; cm_pht_idx = '0;
  endtask

  task automatic set_slot(input int i, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt,
                          input logic [PW-1:0] idx);
    cm_valid[i] = 1'b1; cm_pc[i] = pc; cm_taken[i] = tk;
    cm_target[i] = tgt; cm_pred_taken[i] = ptk;
    cm_pred_target[i] = ptgt; cm_pht_idx[i] = idx;
  endtask

  task automatic model_reset();
    q.delete(); exp_rv = 0; exp_rpc = '0; exp_cb = 0; exp_cm = 0;
  endtask

  // Applies current inputs for one clock, updating the model from the rules.
  task automatic cycle();
    bit rdy, drop, nrv;
    logic [31:0] nrpc;
    int n;
    ent_t e;
    rdy = (DEPTH - q.size()) >= 2;
    nrv = 0; nrpc = exp_rpc; drop = 0; n = 0;
    if (q.size() != 0 && upd_ready) q.delete(0);
    if (rdy) begin
      for (int i = 0; i < 2; i++) begin
        if (cm_valid[i] && !drop) begin
          e.pht = cm_pht_idx[i]; e.tk = cm_taken[i];
          e.pc = cm_pc[i]; e.tgt = cm_target[i];
          q.push_back(e); n++;
          if (cm_taken[i] != cm_pred_taken[i] ||
              (cm_taken[i] && cm_target[i] != cm_pred_target[i])) begin
            if (!nrv) begin
              nrv = 1;
              nrpc = cm_taken[i] ? cm_target[i] : cm_pc[i] + 32'd4;
            end
            if (i == 0) drop = 1;
          end
        end
      end
    end
    exp_cb = (exp_cb + n > CMAX) ? CMAX : exp_cb + n;
    exp_cm = (exp_cm + nrv > CMAX) ? CMAX : exp_cm + nrv;
    @(posedge clk); #1;
    exp_rv = nrv;
    if (nrv) exp_rpc = nrpc;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr_in(); upd_ready = 1'b0; model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_in(); upd_ready = 1'b0; model_reset();
    #3;
    n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_upd_valid got %b want 0", upd_valid); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rst_redirect got %b want 0", redirect_valid); end
    n_cmp++; if (cm_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cm_ready got %b want 1", cm_ready); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_bad++; $display("FAIL rst_redirect_pc got %h want 0", redirect_pc); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) cycle();
    n_cmp++; if (cnt_branch !== 8'd0 || cnt_mispred !== 8'd0) begin n_bad++; $display("FAIL idle_cnt got %0d/%0d want 0/0", cnt_branch, cnt_mispred); end
    n_cmp++; if (upd_valid !== 1'b0 || cm_ready !== 1'b1) begin n_bad++; $display("FAIL idle_out got v=%b r=%b want 0 1", upd_valid, cm_ready); end
  endtask

  task automatic test_taken_correct();
    do_reset();
    upd_ready = 1'b1;
    set_slot(0, 32'h1000, 1, 32'h2000, 1, 32'h2000, 10'd5);
    cycle(); clr_in();
    n_cmp++; if (upd_valid !== 1'b1) begin n_bad++; $display("FAIL tc_valid got %b want 1", upd_valid); end
    n_cmp++; if (upd_pc !== 32'h1000 || upd_target !== 32'h2000) begin n_bad++; $display("FAIL tc_pc got %h/%h want 1000/2000", upd_pc, upd_target); end
    n_cmp++; if (upd_btb_en !== 1'b1 || upd_taken !== 1'b1 || upd_pht_idx !== 10'd5) begin n_bad++; $display("FAIL tc_fields got %b %b %0d want 1 1 5", upd_btb_en, upd_taken, upd_pht_idx); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL tc_redirect got %b want 0", redirect_valid); end
    n_cmp++; if (cnt_branch !== 8'd1 || cnt_mispred !== 8'd0) begin n_bad++; $display("FAIL tc_cnt got %0d/%0d want 1/0", cnt_branch, cnt_mispred); end
    cycle();
    n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL tc_drain got %b want 0", upd_valid); end
  endtask

  task automatic test_slot0_mispred();
    do_reset();
    set_slot(0, 32'h1000, 0, 32'h2000, 1, 32'h2000, 10'd7);
    set_slot(1, 32'h1100, 1, 32'h1200, 1, 32'h1200, 10'd8);
    cycle(); clr_in();
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004) begin n_bad++; $display("FAIL m0_redirect got %b %h want 1 1004", redirect_valid, redirect_pc); end
    n_cmp++; if (upd_pc !== 32'h1000 || upd_taken !== 1'b0 || upd_btb_en !== 1'b0) begin n_bad++; $display("FAIL m0_head got %h %b %b want 1000 0 0", upd_pc, upd_taken, upd_btb_en); end
    n_cmp++; if (cnt_branch !== 8'd1 || cnt_mispred !== 8'd1) begin n_bad++; $display("FAIL m0_cnt got %0d/%0d want 1/1", cnt_branch, cnt_mispred); end
    cycle();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL m0_pulse got %b want 0", redirect_valid); end
    upd_ready = 1'b1;
    cycle();
    n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL m0_one_entry got %b want 0", upd_valid); end
  endtask

  task automatic test_slot1_mispred();
    do_reset();
    set_slot(0, 32'h2000, 0, 32'h0, 0, 32'h0, 10'd1);
    set_slot(1, 32'h3000, 1, 32'h4000, 1, 32'h5000, 10'd2);
    cycle(); clr_in();
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4000) begin n_bad++; $display("FAIL m1_redirect got %b %h want 1 4000", redirect_valid, redirect_pc); end
    n_cmp++; if (cnt_branch !== 8'd2 || cnt_mispred !== 8'd1) begin n_bad++; $display("FAIL m1_cnt got %0d/%0d want 2/1", cnt_branch, cnt_mispred); end
    n_cmp++; if (upd_pc !== 32'h2000) begin n_bad++; $display("FAIL m1_first got %h want 2000", upd_pc); end
    upd_ready = 1'b1;
    cycle();
    n_cmp++; if (upd_valid !== 1'b1 || upd_pc !== 32'h3000 || upd_target !== 32'h4000) begin n_bad++; $display("FAIL m1_second got %b %h %h want 1 3000 4000", upd_valid, upd_pc, upd_target); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL m1_pulse got %b want 0", redirect_valid); end
    cycle();
    n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL m1_drain got %b want 0", upd_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] order[$];
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_slot(0, 32'h8000 + c * 32'h20, 1, 32'h9000 + c, 1, 32'h9000 + c, 10'(c));
      if (c > 0)
        set_slot(1, 32'h8004 + c * 32'h20, 0, 32'h0, 0, 32'h0, 10'(c + 16));
      if (c < 4) order.push_back(32'h8000 + c * 32'h20);
      if (c > 0 && c < 4) order.push_back(32'h8004 + c * 32'h20);
      cycle();
      n_cmp++; if (cm_ready !== ((DEPTH - q.size()) >= 2)) begin n_bad++; $display("FAIL bp_ready c=%0d got %b", c, cm_ready); end
      n_cmp++; if (upd_pc !== 32'h8000) begin n_bad++; $display("FAIL bp_stall c=%0d got %h want 8000", c, upd_pc); end
    end
    n_cmp++; if (cm_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full7 got %b want 0", cm_ready); end
    clr_in();
    upd_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      n_cmp++; if (upd_valid !== 1'b1 || upd_pc !== order[k]) begin n_bad++; $display("FAIL bp_order k=%0d got %b %h want 1 %h", k, upd_valid, upd_pc, order[k]); end
      cycle();
    end
    n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", upd_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_slot(0, 32'hA000 + c * 32'h10, 0, 32'h0, 0, 32'h0, 10'd3);
      if (c > 0) set_slot(1, 32'hA004 + c * 32'h10, 0, 32'h0, 0, 32'h0, 10'd4);
      cycle(); clr_in();
    end
    n_cmp++; if (cm_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_cnt5 got %b want 1", cm_ready); end
    upd_ready = 1'b1;
    set_slot(0, 32'hB000, 0, 32'h0, 0, 32'h0, 10'd9);
    set_slot(1, 32'hB004, 0, 32'h0, 0, 32'h0, 10'd9);
    cycle(); clr_in();
    upd_ready = 1'b0;
    n_cmp++; if (cm_ready !== 1'b1 || upd_pc !== 32'hA010) begin n_bad++; $display("FAIL b2b_cnt6 got %b %h want 1 a010", cm_ready, upd_pc); end
    set_slot(0, 32'hC000, 0, 32'h0, 0, 32'h0, 10'd9);
    set_slot(1, 32'hC004, 0, 32'h0, 0, 32'h0, 10'd9);
    cycle(); clr_in();
    n_cmp++; if (cm_ready !== 1'b0 || cnt_branch !== 8'd9) begin n_bad++; $display("FAIL b2b_full got %b %0d want 0 9", cm_ready, cnt_branch); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    upd_ready = 1'b1;
    set_slot(0, 32'hD000, 0, 32'h0, 0, 32'h0, 10'd1);
    set_slot(1, 32'hD004, 0, 32'h0, 0, 32'h0, 10'd1);
    cycle();
    set_slot(0, 32'hE000, 1, 32'hE100, 0, 32'h0, 10'd1);
    cycle(); clr_in();
    n_cmp++; if (redirect_valid !== 1'b1 || upd_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre got %b %b want 1 1", redirect_valid, upd_valid); end
    rst = 1'b1; model_reset();
    #1;
    n_cmp++; if (upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rm_async got %b %b want 0 0", upd_valid, redirect_valid); end
    n_cmp++; if (cnt_branch !== 8'd0 || cnt_mispred !== 8'd0 || cm_ready !== 1'b1) begin n_bad++; $display("FAIL rm_state got %0d %0d %b want 0 0 1", cnt_branch, cnt_mispred, cm_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] pc, tgt;
    logic tk;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      clr_in();
      upd_ready = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < 2; i++) begin
        if ((i == 0 && $urandom_range(0, 9) < 7) ||
            (i == 1 && cm_valid[0] && $urandom_range(0, 1) == 1)) begin
          pc = {$urandom_range(0, 32'hFFFF), 2'b00};
          if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
          tgt = {$urandom_range(0, 32'hFFFF), 2'b00};
          tk = $urandom_range(0, 1);
          case ($urandom_range(0, 9))
            0, 1: set_slot(i, pc, tk, tgt, ~tk, tgt, 10'($urandom));
            2: set_slot(i, pc, tk, tgt, tk, tgt ^ 32'h40, 10'($urandom));
            default: set_slot(i, pc, tk, tgt, tk, tgt, 10'($urandom));
          endcase
        end
      end
      n_cmp++; if (upd_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid c=%0d got %b", c, upd_valid); end
      n_cmp++; if (cm_ready !== ((DEPTH - q.size()) >= 2)) begin n_bad++; $display("FAIL rnd_ready c=%0d got %b", c, cm_ready); end
      if (q.size() != 0) begin
        n_cmp++;
        if (upd_pc !== q[0].pc || upd_target !== q[0].tgt || upd_pht_idx !== q[0].pht ||
            upd_taken !== q[0].tk || upd_btb_en !== q[0].tk) begin
          n_bad++;
          $display("FAIL rnd_head c=%0d got %h %h %0d %b %b want %h %h %0d %b", c, upd_pc, upd_target,
                   upd_pht_idx, upd_taken, upd_btb_en, q[0].pc, q[0].tgt, q[0].pht, q[0].tk);
        end
      end
      n_cmp++; if (redirect_valid !== exp_rv) begin n_bad++; $display("FAIL rnd_rv c=%0d got %b want %b", c, redirect_valid, exp_rv); end
      if (exp_rv) begin
        n_cmp++; if (redirect_pc !== exp_rpc) begin n_bad++; $display("FAIL rnd_rpc c=%0d got %h want %h", c, redirect_pc, exp_rpc); end
      end
      n_cmp++; if (cnt_branch !== CW'(exp_cb) || cnt_mispred !== CW'(exp_cm)) begin n_bad++; $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d", c, cnt_branch, cnt_mispred, exp_cb, exp_cm); end
      cycle();
    end
    n_cmp++; if (cnt_branch !== 8'hFF) begin n_bad++; $display("FAIL rnd_sat got %0d want 255", cnt_branch); end
  endtask

  initial begin
    rst = 1'b1;
    upd_ready = 1'b0;
    clr_in();
    #1;
    test_reset();
    test_taken_correct();
    test_slot0_mispred();
    test_slot1_mispred();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
